rst_seq_sync: RTL



---
 rtl/rst_seq_sync.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rst_seq_sync.sv
// Multi-channel reset synchronizer and sequencer: synchronizes an async active-low
// reset, holds, then releases NUM_CH channel resets in order; supports SW re-runs.
module rst_seq_sync #(
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE,
  output logic              RST_CAUSE
);

  localparam int unsigned MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CNT) + 1;
  localparam int unsigned CHW     = $clog2(NUM_CH) + 1;

  localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CHW-1:0] CH_LAST   = CHW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    HOLD,
    RELEASE,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_STAGES-1:0] sync_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CHW-1:0]      ch_q, ch_d;
  logic [NUM_CH-1:0]   sync_rst_q, sync_rst_d;
  logic                done_q, done_d;
  logic                cause_q, cause_d;
  logic                rst_ok;
  logic                sw_accept;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '0;
    else      sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
  end

  assign rst_ok    = sync_q[NUM_STAGES-1];
  assign sw_accept = SW_RST_REQ && rst_ok && (state_q != WAIT_SYNC);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= WAIT_SYNC;
      cnt_q      <= '0;
      ch_q       <= '0;
      sync_rst_q <= '0;
      done_q     <= 1'b0;
      cause_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      sync_rst_q <= sync_rst_d;
      done_q     <= done_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    sync_rst_d = sync_rst_q;
    done_d     = done_q;
    cause_d    = cause_q;
    if (sw_accept) begin
      state_d    = HOLD;
      cnt_d      = '0;
      ch_d       = '0;
      sync_rst_d = '0;
      done_d     = 1'b0;
      cause_d    = 1'b1;
    end else begin
      case (state_q)
        // Leave one edge early (on the bit about to become rst_ok) so the hold
        // count starts at the edge where rst_ok rises.
        WAIT_SYNC: begin
          if (sync_q[NUM_STAGES-2]) begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            sync_rst_d[0] = 1'b1;
            cnt_d         = '0;
            ch_d          = CHW'(1);
            if (NUM_CH == 1) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (CHW'(i) == ch_q) sync_rst_d[i] = 1'b1;
            end
            cnt_d = '0;
            ch_d  = ch_q + CHW'(1);
            if (ch_q == CH_LAST) begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE:    state_d = DONE;
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  assign SYNC_RST  = sync_rst_q;
  assign RST_DONE  = done_q;
  assign RST_CAUSE = cause_q;

endmodule
